// File: rtl/uart_tx_fifo_drain.sv
// UART 8N1 transmitter draining a registered-read FIFO onto a tx line.
// Ports: clk, rst (async low), fifo_empty/fifo_dout in; fifo_pop, tx, busy, frame_done out.
module uart_tx_fifo_drain #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_WIDTH   = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_pop,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_WIDTH) + 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] DAT_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] STP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    STOP
  } state_e;

  state_e                state_q;
  logic [CW-1:0]         baud_q;
  logic [BW-1:0]         bit_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  tx_q;
  logic                  pop_q;
  logic                  busy_q;
  logic                  done_q;

  // Outputs are registered with the value belonging to the next state.
  // bit_q doubles as the stop-bit counter while in STOP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      pop_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      pop_q  <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q <= POP;
            pop_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        POP: begin
          state_q <= LOAD;
        end
        LOAD: begin
          // fifo_dout is valid only in this cycle
          shift_q <= fifo_dout;
          baud_q  <= '0;
          bit_q   <= '0;
          tx_q    <= 1'b0;
          state_q <= START;
        end
        START: begin
          if (baud_q == CNT_LAST) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_q == CNT_LAST) begin
            baud_q  <= '0;
            shift_q <= shift_q >> 1;
            if (bit_q == DAT_LAST) begin
              bit_q   <= '0;
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + 1'b1;
              tx_q  <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        STOP: begin
          // set one edge early so the pulse sits on the last stop cycle
          if (baud_q == CNT_PRE && bit_q == STP_LAST) begin
            done_q <= 1'b1;
          end
          if (baud_q == CNT_LAST) begin
            baud_q <= '0;
            if (bit_q == STP_LAST) begin
              bit_q   <= '0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_pop   = pop_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule
